// File: rtl/sipo_deser_pkg.sv
// Shared sizing helpers for the SIPO deserializer family.
// Word beats per lane width and the beat counter width derived from it.
package sipo_pkg;

    function automatic int beats(input int data_width, input int lane_width);
        return (lane_width < 1) ? data_width : data_width / lane_width;
    endfunction

    // A single-beat word still gets a 1-bit counter so ports never collapse to zero width.
    function automatic int cnt_w(input int n_beats);
        return (n_beats <= 2) ? 1 : $clog2(n_beats);
    endfunction

endpackage

// File: rtl/sipo_deser_shift_core.sv
// Lane shift register and beat counter with realign handling.
// Emits a combinational word_done pulse and the completed word on the final beat.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 1,
    parameter bit MSB_FIRST  = 1'b1,
    localparam int BEATS     = beats(DATA_WIDTH, LANE_WIDTH),
    localparam int CNT_W     = cnt_w(BEATS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din_valid,
    input  logic [LANE_WIDTH-1:0] din,
    input  logic                  sync,
    output logic [CNT_W-1:0]      beat_cnt,
    output logic                  word_done,
    output logic [DATA_WIDTH-1:0] word
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    logic [DATA_WIDTH-1:0] sreg;
    logic [DATA_WIDTH-1:0] base_sreg;
    logic [DATA_WIDTH-1:0] shifted;
    logic [CNT_W-1:0]      base_cnt;

    // Realign clears state first so a beat in the same cycle becomes beat 0.
    always_comb begin
        base_sreg = sync ? '0 : sreg;
        base_cnt  = sync ? '0 : beat_cnt;
    end

    generate
        if (BEATS == 1) begin : g_single
            assign shifted = din;
        end else if (MSB_FIRST) begin : g_msb
            assign shifted = {base_sreg[DATA_WIDTH-LANE_WIDTH-1:0], din};
        end else begin : g_lsb
            assign shifted = {din, base_sreg[DATA_WIDTH-1:LANE_WIDTH]};
        end
    endgenerate

    assign word_done = din_valid && (base_cnt == LAST);
    assign word      = shifted;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sreg     <= '0;
            beat_cnt <= '0;
        end else if (din_valid) begin
            sreg     <= shifted;
            beat_cnt <= word_done ? '0 : base_cnt + CNT_W'(1);
        end else begin
            sreg     <= base_sreg;
            beat_cnt <= base_cnt;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: lane assembly plus a one-word valid/ready
// holding register that drops completed words under backpressure and flags it.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 1,
    parameter bit MSB_FIRST  = 1'b1,
    localparam int BEATS     = beats(DATA_WIDTH, LANE_WIDTH),
    localparam int CNT_W     = cnt_w(BEATS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din_valid,
    input  logic [LANE_WIDTH-1:0] din,
    input  logic                  sync,
    input  logic                  dout_ready,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CNT_W-1:0]      beat_cnt,
    output logic                  overrun
);

    generate
        if (LANE_WIDTH < 1) begin : g_bad_lane
            $error("sipo_deser: LANE_WIDTH must be at least 1");
        end
        if ((LANE_WIDTH >= 1) && (DATA_WIDTH % LANE_WIDTH != 0)) begin : g_bad_ratio
            $error("sipo_deser: DATA_WIDTH must be a multiple of LANE_WIDTH");
        end
    endgenerate

    logic                  word_done;
    logic [DATA_WIDTH-1:0] word;
    logic                  hold_free;

    sipo_shift_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_WIDTH (LANE_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .resetn    (resetn),
        .din_valid (din_valid),
        .din       (din),
        .sync      (sync),
        .beat_cnt  (beat_cnt),
        .word_done (word_done),
        .word      (word)
    );

    // Holding register can take a new word if empty or being drained this cycle.
    assign hold_free = !dout_valid || dout_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= word_done && !hold_free;
            if (word_done && hold_free) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule
